// File: rtl/core_if_buf_pkg.sv
// Shared defaults and helpers for the instruction-fetch buffer slice.
package core_if_buf_pkg;

  // Default fetch address and data widths
  localparam int unsigned IF_ADDR_W      = 32;
  localparam int unsigned IF_INSTR_W     = 32;

  // Default buffer depth (in-flight plus buffered instructions)
  localparam int unsigned IF_FETCH_DEPTH = 4;

  // Address of the first fetch after reset
  localparam logic [31:0] IF_PC_START    = 32'h0000_0200;

  // Counters must hold the value "depth" itself, so one extra bit is needed
  function automatic int unsigned ifCntWidth(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/core_if_fifo.sv
// Synchronous FIFO with flush, used to buffer {pc, pc+4, instr} entries
// between the L1I response port and decode.
module core_if_fifo
  import core_if_buf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        i_flush,
  input  logic                        i_push,
  input  logic [WIDTH-1:0]            i_pushData,
  input  logic                        i_pop,
  output logic [WIDTH-1:0]            o_popData,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [ifCntWidth(DEPTH)-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = ifCntWidth(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPop;

  // Popping an empty FIFO is a no-op; pushes are trusted to find room
  assign w_doPop   = i_pop && (r_count != '0);

  assign o_popData = r_mem[r_rdPtr];
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;

  // Storage, pointers and occupancy; flush empties the FIFO without touching data
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wrPtr] <= i_pushData;
        r_wrPtr        <= r_wrPtr + PTR_W'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(w_doPop);
    end
  end

endmodule

// File: rtl/core_if_buf.sv
// Instruction-fetch stage: owns the PC, issues sequential L1I requests under
// a credit limit, buffers returned instructions for decode, and flushes on
// redirect while discarding responses that belong to the old path.
module core_if_buf
  import core_if_buf_pkg::*;
#(
  parameter int                ADDR_W      = IF_ADDR_W,
  parameter int                INSTR_W     = IF_INSTR_W,
  parameter int                FETCH_DEPTH = IF_FETCH_DEPTH,
  parameter logic [ADDR_W-1:0] PC_START    = ADDR_W'(IF_PC_START)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               if_stop_in,
  input  logic               if_redirect_in,
  input  logic [ADDR_W-1:0]  if_redirect_addr_in,
  output logic               if_l1i_req_val_out,
  output logic [ADDR_W-1:0]  if_l1i_req_addr_out,
  input  logic               if_l1i_req_rdy_in,
  input  logic               if_l1i_resp_val_in,
  input  logic [INSTR_W-1:0] if_l1i_resp_data_in,
  output logic               if_dec_val_out,
  output logic [ADDR_W-1:0]  if_dec_pc_out,
  output logic [ADDR_W-1:0]  if_dec_pc_4_out,
  output logic [INSTR_W-1:0] if_dec_instr_out,
  input  logic               if_dec_rdy_in
);

  localparam int CNT_W   = ifCntWidth(FETCH_DEPTH);
  localparam int ENTRY_W = 2 * ADDR_W + INSTR_W;

  logic [ADDR_W-1:0]  r_fetchPc;
  logic [ADDR_W-1:0]  r_respPc;
  logic [CNT_W-1:0]   r_outstanding;
  logic [CNT_W-1:0]   r_dropCnt;

  logic [CNT_W-1:0]   w_fifoCount;
  logic               w_fifoEmpty;
  logic               w_unusedFull;
  logic [CNT_W:0]     w_creditSum;
  logic               w_reqFire;
  logic               w_dropResp;
  logic               w_pushFire;
  logic               w_popFire;
  logic [ADDR_W-1:0]  w_redirectPc;
  logic [ADDR_W-1:0]  w_respPc4;
  logic [ENTRY_W-1:0] w_pushData;
  logic [ENTRY_W-1:0] w_headData;
  logic               w_unusedAddrLsb;

  // Redirect targets are word aligned; the low address bits carry no meaning
  assign w_redirectPc    = {if_redirect_addr_in[ADDR_W-1:2], 2'b00};
  assign w_unusedAddrLsb = ^if_redirect_addr_in[1:0];

  // Everything in flight or buffered occupies a FIFO slot, so the sum bounds issue
  assign w_creditSum = {1'b0, r_outstanding} + {1'b0, w_fifoCount};

  assign if_l1i_req_val_out  = n_rst && !if_stop_in && !if_redirect_in &&
                               (w_creditSum < (CNT_W + 1)'(FETCH_DEPTH));
  assign if_l1i_req_addr_out = r_fetchPc;

  assign w_reqFire  = if_l1i_req_val_out && if_l1i_req_rdy_in;
  assign w_dropResp = if_l1i_resp_val_in && (r_dropCnt != '0);
  assign w_pushFire = if_l1i_resp_val_in && (r_dropCnt == '0) && !if_redirect_in;
  assign w_popFire  = if_dec_rdy_in && !w_fifoEmpty && !if_redirect_in;

  assign w_respPc4  = r_respPc + ADDR_W'(4);
  assign w_pushData = {r_respPc, w_respPc4, if_l1i_resp_data_in};

  assign if_dec_val_out   = !w_fifoEmpty;
  assign if_dec_pc_out    = w_headData[ENTRY_W-1 -: ADDR_W];
  assign if_dec_pc_4_out  = w_headData[INSTR_W +: ADDR_W];
  assign if_dec_instr_out = w_headData[INSTR_W-1:0];

  // Fetch and response PCs: redirect reloads both, otherwise each advances on its own event
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_fetchPc <= PC_START;
      r_respPc  <= PC_START;
    end else if (if_redirect_in) begin
      r_fetchPc <= w_redirectPc;
      r_respPc  <= w_redirectPc;
    end else begin
      if (w_reqFire) begin
        r_fetchPc <= r_fetchPc + ADDR_W'(4);
      end
      if (w_pushFire) begin
        r_respPc <= w_respPc4;
      end
    end
  end

  // In-flight and stale-response counters; on redirect every older request becomes stale
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_outstanding <= '0;
      r_dropCnt     <= '0;
    end else if (if_redirect_in) begin
      r_outstanding <= r_outstanding - CNT_W'(if_l1i_resp_val_in);
      r_dropCnt     <= r_outstanding - CNT_W'(if_l1i_resp_val_in);
    end else begin
      r_outstanding <= r_outstanding + CNT_W'(w_reqFire) - CNT_W'(if_l1i_resp_val_in);
      if (w_dropResp) begin
        r_dropCnt <= r_dropCnt - CNT_W'(1);
      end
    end
  end

  core_if_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FETCH_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .n_rst      (n_rst),
    .i_flush    (if_redirect_in),
    .i_push     (w_pushFire),
    .i_pushData (w_pushData),
    .i_pop      (w_popFire),
    .o_popData  (w_headData),
    .o_full     (w_unusedFull),
    .o_empty    (w_fifoEmpty),
    .o_count    (w_fifoCount)
  );

endmodule

// File: tb/tb_core_if_buf.sv
// Self-checking bench for core_if_buf: an in-order L1I model answers requests,
// and a scoreboard predicts the decode stream from fetch-path epochs.
module tb_core_if_buf;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] PC_START = 32'h0000_0200;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
  } reqT;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } entT;

  logic        clk;
  logic        n_rst;
  logic        stopIn;
  logic        redirIn;
  logic [31:0] redirAddr;
  logic        reqVal;
  logic [31:0] reqAddr;
  logic        l1Rdy;
  logic        respVal;
  logic [31:0] respData;
  logic        decVal;
  logic [31:0] decPc;
  logic [31:0] decPc4;
  logic [31:0] decInstr;
  logic        decRdy;

  reqT         l1Q[$];
  entT         expQ[$];
  int          epoch;
  logic [31:0] nextAddr;
  int          testsRun;
  int          testsFailed;
  int          popCount;
  int          respMode;
  int          rdyMode;
  bit          monEnable;

  core_if_buf dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .if_stop_in          (stopIn),
    .if_redirect_in      (redirIn),
    .if_redirect_addr_in (redirAddr),
    .if_l1i_req_val_out  (reqVal),
    .if_l1i_req_addr_out (reqAddr),
    .if_l1i_req_rdy_in   (l1Rdy),
    .if_l1i_resp_val_in  (respVal),
    .if_l1i_resp_data_in (respData),
    .if_dec_val_out      (decVal),
    .if_dec_pc_out       (decPc),
    .if_dec_pc_4_out     (decPc4),
    .if_dec_instr_out    (decInstr),
    .if_dec_rdy_in       (decRdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of instruction memory as seen by the L1I model
  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic stopV, input logic decRdyV, input int cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
      stopIn  = stopV;
      decRdy  = decRdyV;
      redirIn = 1'b0;
    end
  endtask

  task automatic pulseRedirect(input logic [31:0] a);
    @(posedge clk); #1;
    redirIn   = 1'b1;
    redirAddr = a;
    @(posedge clk); #1;
    redirIn   = 1'b0;
  endtask

  task automatic waitInflight(input int n, input int budget);
    bit found;
    found = 1'b0;
    for (int k = 0; k < budget && !found; k++) begin
      @(posedge clk); #1;
      if (l1Q.size() >= n) found = 1'b1;
    end
    checkOutput("waitInflight", 32'(found), 32'd1);
  endtask

  // L1I model: in-order responses, readiness and response timing set by mode
  initial begin : l1Responder
    l1Rdy    = 1'b0;
    respVal  = 1'b0;
    respData = '0;
    @(posedge n_rst);
    forever begin
      @(posedge clk); #1;
      l1Rdy = (rdyMode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      if (l1Q.size() > 0 && (respMode == 1 || (respMode == 0 && $urandom_range(0, 2) != 0))) begin
        respVal  = 1'b1;
        respData = instrOf(l1Q[0].addr);
      end else begin
        respVal  = 1'b0;
        respData = $urandom;
      end
    end
  end

  // Scoreboard: compare the DUT against the epoch model, then advance the model by this cycle's events
  always @(negedge clk) begin : monitor
    reqT  r;
    entT  e;
    entT  h;
    logic expReq;
    if (monEnable) begin
      expReq = !stopIn && !redirIn && (l1Q.size() + expQ.size() < DEPTH);
      checkOutput("reqVal", 32'(reqVal), 32'(expReq));
      checkOutput("reqAddr", reqAddr, nextAddr);
      checkOutput("decVal", 32'(decVal), 32'(expQ.size() != 0));
      if (decVal && expQ.size() != 0) begin
        h = expQ[0];
        checkOutput("decPc", decPc, h.pc);
        checkOutput("decPc4", decPc4, h.pc4);
        checkOutput("decInstr", decInstr, h.instr);
        if (decRdy && !redirIn) begin
          h = expQ.pop_front();
          popCount++;
        end
      end
      if (respVal && l1Q.size() != 0) begin
        r = l1Q.pop_front();
        if (!redirIn && r.epoch == epoch) begin
          checkOutput("creditRoom", 32'(expQ.size() < DEPTH), 32'd1);
          e.pc    = r.addr;
          e.pc4   = r.addr + 32'd4;
          e.instr = instrOf(r.addr);
          expQ.push_back(e);
        end
      end
      if (reqVal && l1Rdy) begin
        r.addr  = nextAddr;
        r.epoch = epoch;
        l1Q.push_back(r);
        nextAddr = nextAddr + 32'd4;
      end
      if (redirIn) begin
        epoch++;
        expQ.delete();
        nextAddr = {redirAddr[31:2], 2'b00};
      end
    end
  end

  // Directed scenarios followed by a randomized run and a bounded drain
  initial begin : driver
    bit done;
    n_rst       = 1'b0;
    stopIn      = 1'b0;
    redirIn     = 1'b0;
    redirAddr   = '0;
    decRdy      = 1'b0;
    monEnable   = 1'b0;
    testsRun    = 0;
    testsFailed = 0;
    popCount    = 0;
    epoch       = 0;
    nextAddr    = PC_START;
    respMode    = 1;
    rdyMode     = 1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstReqVal", 32'(reqVal), 32'd0);
    checkOutput("rstReqAddr", reqAddr, PC_START);
    checkOutput("rstDecVal", 32'(decVal), 32'd0);
    checkOutput("rstDecPc", decPc, 32'd0);
    checkOutput("rstDecPc4", decPc4, 32'd0);
    checkOutput("rstDecInstr", decInstr, 32'd0);

    @(posedge clk); #1;
    n_rst     = 1'b1;
    decRdy    = 1'b1;
    monEnable = 1'b1;

    // Steady streaming, then a redirect that lands with a response and a pop
    applyStimulus(1'b0, 1'b1, 20);
    pulseRedirect(32'h0000_0406);
    @(negedge clk);
    checkOutput("redirStreamDecVal", 32'(decVal), 32'd0);
    applyStimulus(1'b0, 1'b1, 8);

    // Decode back-pressure fills the buffer, then release
    applyStimulus(1'b0, 1'b0, 12);
    @(negedge clk);
    checkOutput("fullReqVal", 32'(reqVal), 32'd0);
    applyStimulus(1'b0, 1'b1, 8);

    // Three requests in flight, redirect to an unaligned target
    respMode = 2;
    waitInflight(3, 20);
    respMode = 1;
    pulseRedirect(32'h0000_1003);
    @(negedge clk);
    checkOutput("redirReqAddr", reqAddr, 32'h0000_1000);
    checkOutput("redirReqVal", 32'(reqVal), 32'd1);
    checkOutput("redirDecVal", 32'(decVal), 32'd0);
    applyStimulus(1'b0, 1'b1, 10);

    // Stall with requests outstanding: they still land, issue resumes afterwards
    respMode = 2;
    waitInflight(2, 20);
    stopIn   = 1'b1;
    respMode = 1;
    applyStimulus(1'b1, 1'b1, 5);
    applyStimulus(1'b0, 1'b1, 10);

    // Address wrap at the top of the space
    pulseRedirect(32'hFFFF_FFF9);
    @(negedge clk);
    checkOutput("wrapReqAddr", reqAddr, 32'hFFFF_FFF8);
    applyStimulus(1'b0, 1'b1, 12);

    // Randomized traffic on every input
    rdyMode  = 0;
    respMode = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      stopIn    = ($urandom_range(0, 9) == 0);
      decRdy    = ($urandom_range(0, 3) != 0);
      redirIn   = ($urandom_range(0, 39) == 0);
      redirAddr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : $urandom;
    end

    // Drain everything still in flight or buffered
    @(posedge clk); #1;
    redirIn  = 1'b0;
    stopIn   = 1'b1;
    decRdy   = 1'b1;
    respMode = 1;
    done     = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(posedge clk); #1;
      if (l1Q.size() == 0 && expQ.size() == 0) done = 1'b1;
    end
    checkOutput("drainDone", 32'(done), 32'd1);
    checkOutput("popsSeen", 32'(popCount > 200), 32'd1);

    @(negedge clk);
    monEnable = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/core_if_buf.md
Name: core_if_buf

Overview:
- Parametrised instruction-fetch stage with a decoupling buffer.
- Owns the PC and issues sequential fetches to L1I over a valid/ready request channel, with any number of requests in flight up to FETCH_DEPTH.
- Queues returned instructions with their PC and PC+4 in a FIFO and presents them to decode through a valid/ready handshake.
- Redirects from branch/hazard control flush the buffer and discard stale in-flight responses.

Parameters:
- ADDR_W, 32, PC/address width.
- INSTR_W, 32, instruction width.
- FETCH_DEPTH, 4, FIFO entries and the maximum in-flight plus buffered instructions (power of 2, >=2).
- PC_START, 32'h0000_0200, reset PC (default from core_defines.vh).

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous reset, active low
- if_stop_in  in  1  hazard stall; blocks new L1I requests only
- if_redirect_in  in  1  redirect/flush pulse
- if_redirect_addr_in  in  ADDR_W  new fetch address; bits [1:0] ignored and treated as 0
- if_l1i_req_val_out  out  1  fetch request valid
- if_l1i_req_addr_out  out  ADDR_W  fetch address
- if_l1i_req_rdy_in  in  1  L1I accepts request
- if_l1i_resp_val_in  in  1  in-order response valid; always accepted
- if_l1i_resp_data_in  in  INSTR_W  fetched instruction
- if_dec_val_out  out  1  head entry valid
- if_dec_pc_out  out  ADDR_W  PC of head entry
- if_dec_pc_4_out  out  ADDR_W  PC+4 of head entry
- if_dec_instr_out  out  INSTR_W  instruction of head entry
- if_dec_rdy_in  in  1  decode consumes head

Behaviour:
- Interface: one clock, clk. Reset n_rst is asynchronous and active low.
- Reset values:
  - fetch_pc = resp_pc = PC_START.
  - outstanding, drop_cnt and FIFO count all = 0.
  - if_l1i_req_val_out = 0 and if_l1i_req_addr_out = PC_START.
  - if_dec_val_out = 0; if_dec_pc_out, if_dec_pc_4_out and if_dec_instr_out all = 0.
  - Reset mid-operation discards all state, including in-flight responses. The L1I side is reset together with this block.
- Request side:
  - req_val = !if_stop_in && !if_redirect_in && (outstanding + fifo_count < FETCH_DEPTH).
  - req_addr = fetch_pc.
  - A request is accepted when val && rdy. On accept, fetch_pc += 4 (wraps modulo 2^ADDR_W) and outstanding increments.
  - req_val and req_addr are combinational from registers, and must stay stable while val && !rdy unless a redirect arrives.
- Response side:
  - A response decrements outstanding.
  - If drop_cnt > 0: the response is discarded and drop_cnt decrements.
  - Otherwise: push {resp_pc, resp_pc+4, data} into the FIFO, then resp_pc += 4.
  - Credit accounting guarantees the FIFO is never full on push. The bench asserts this; it is not handled in logic.
- Decode side:
  - if_dec_val_out = FIFO not empty. Outputs show the head entry.
  - Pop when val && rdy.
  - Latency: response in cycle N, visible to decode in N+1 (no bypass).
  - Push and pop in the same cycle leave the count unchanged. The full and empty pointers wrap modulo FETCH_DEPTH.
- Redirect, if_redirect_in=1 in cycle N, takes priority over all other events:
  - fetch_pc = resp_pc = {addr[ADDR_W-1:2], 2'b00}.
  - FIFO is cleared, and if_dec_val_out = 0 in N+1.
  - No request is issued in N.
  - drop_cnt = outstanding - resp_val_N. Any response in N is itself dropped.
  - A pop in N is ignored.
  - The first request at the new address appears in N+1.
  - Back-to-back redirects each reload drop_cnt the same way; the last one wins.
- if_stop_in:
  - Only suppresses issue. In-flight responses still land and decode may still drain.
  - A redirect during stall updates the PC, and issue resumes at the new PC after the stall drops.
- Counters are $clog2(FETCH_DEPTH)+1 bits wide.

Decomposition:
- core_defines.vh: PC_START default and the instruction-width constant. No new typedefs are needed.
- One natural sub-module, core_if_fifo:
  - Synchronous FIFO parametrised by width and depth, with a flush input, push/pop, full/empty/count outputs.
  - Reused for the {pc, pc+4, instr} entries.
- PC, resp_pc, the outstanding/drop counters and the issue logic stay in core_if_buf.

Test Plan:
- Reset release, L1I rdy=1 and responds 1 cycle later, decode rdy=1 -> requests at 0x200, 0x204, 0x208... Decode sees pc=0x200 / pc_4=0x204 with the matching instr two cycles after the first request.
- Decode rdy=0 with L1I always responding -> exactly 4 requests issued, then req_val=0. FIFO holds 0x200..0x20C. Raising rdy resumes issue 1 cycle after the first pop.
- 3 requests in flight, then redirect to 0x1003 -> the next request is at 0x1000. The 3 stale responses are dropped. The first decode entry is pc=0x1000.
- Redirect in the same cycle as a response and a decode pop -> that response is dropped, the FIFO is empty next cycle, and drop_cnt = outstanding-1.
- if_stop_in=1 for 5 cycles with 2 requests outstanding -> no new requests, both responses delivered in order. Issue resumes at the next sequential PC when the stall drops.
- fetch_pc=0xFFFF_FFFC -> the following request address wraps to 0x0000_0000, and pc_4_out of that entry = 0x0000_0000.
